s32x_sh2_bus_arb: RTL and testbench
===================================

Name: s32x_sh2_bus_arb

Overview:
- Shares the single external 32X system bus between the master SH-2 and the slave SH-2 bus-state controllers.
- Implements the master/slave bus-release handshake:
  - slave BREQ_N is forwarded to master BRLS_N;
  - master BGR_N is converted to slave BACK_N.
- Muxes the owning CPU's bus outputs onto the shared bus and routes WAIT_N back to the owner.
- Sits between the two SH7604 instances and the 32X address decoder.

Parameters:
- WDT_LIMIT, 8'd255, CE_F ticks allowed in FWD before ERR is set. Only used with S32X_BUS_ARB_WDT_EN.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active high
- CE_R  in  1  SH-2 rising-phase clock enable
- CE_F  in  1  SH-2 falling-phase clock enable; all arbitration state updates on CE_F only
- MST_A, SLV_A  in  27 each  CPU address
- MST_DO, SLV_DO  in  32 each  CPU write data
- MST_BS_N, SLV_BS_N  in  1 each  bus start
- MST_CS_N, SLV_CS_N  in  4 each  chip selects {CS3..CS0}
- MST_RD_WR_N, SLV_RD_WR_N  in  1 each  read/write
- MST_RD_N, SLV_RD_N  in  1 each  read strobe
- MST_WE_N, SLV_WE_N  in  4 each  byte write strobes
- MST_IVECF_N, SLV_IVECF_N  in  1 each  vector fetch
- MST_BGR_N  in  1  master bus grant
- SLV_BREQ_N  in  1  slave bus request
- MST_BRLS_N  out  1  release request to master
- SLV_BACK_N  out  1  acknowledge to slave
- MST_WAIT_N, SLV_WAIT_N  out  1 each  per-CPU wait
- A  out  27  shared address
- DO  out  32  shared write data
- BS_N  out  1  shared bus start
- CS_N  out  4  shared chip selects
- RD_WR_N  out  1  shared read/write
- RD_N  out  1  shared read strobe
- WE_N  out  4  shared byte write strobes
- IVECF_N  out  1  shared vector fetch
- WAIT_N  in  1  shared-bus wait from the target
- OWNER  out  1  bus owner; 0 = master, 1 = slave
- ERR  out  1  sticky grant timeout; constant 0 without the macro

Behaviour:
- Reset (RST high, asynchronous):
  - state = MST, OWNER = 0, MST_BRLS_N = 1, SLV_BACK_N = 1, ERR = 0, watchdog counter = 0.
  - Shared bus then mirrors the master inputs.
- State register: MST, FWD, SLV, RET. Updates only when CE_F = 1.
- MST:
  - If SLV_BREQ_N = 0: MST_BRLS_N <= 0, go to FWD.
- FWD:
  - If SLV_BREQ_N = 1 (request withdrawn): MST_BRLS_N <= 1, go to RET.
  - Else if MST_BGR_N = 0: SLV_BACK_N <= 0, OWNER <= 1, go to SLV.
  - Withdrawal has priority over a grant seen on the same tick.
- SLV:
  - If SLV_BREQ_N = 1: SLV_BACK_N <= 1, MST_BRLS_N <= 1, go to RET.
  - OWNER stays 1 in this tick.
- RET:
  - If MST_BGR_N = 1: OWNER <= 0, go to MST.
  - A new SLV_BREQ_N = 0 seen in RET is not serviced until MST is reached (no back-to-back grant without a master window).
- Shared-bus mux (combinational): OWNER selects the A, DO, BS_N, CS_N, RD_WR_N, RD_N, WE_N and IVECF_N group. Zero latency.
- Wait routing:
  - Owner's WAIT_N = shared WAIT_N.
  - Non-owner's WAIT_N = 1.
- Invariants:
  - OWNER changes only while the master holds BGR_N low (switch to slave) or on RET exit. The owner switch is thus always bracketed by the BSC handshakes.
  - SLV_BACK_N = 0 implies MST_BGR_N was 0 when granted.
- Mid-operation reset: outputs return to their reset values immediately, whatever the state.

Optional Feature:
- S32X_BUS_ARB_WDT_EN defined:
  - An 8-bit counter clears on entry to FWD and increments on each CE_F tick spent in FWD.
  - When it reaches WDT_LIMIT, ERR <= 1 (sticky until RST).
  - Arbitration is unaffected.
- Undefined: no counter is built and ERR is tied to 0.

Decomposition:
- Shared SH7604/S32X package holds:
  - ArbState_t enum {MST = 2'b00, FWD = 2'b01, SLV = 2'b10, RET = 2'b11};
  - SH2BusOut_t packed struct {A, DO, BS_N, CS_N, RD_WR_N, RD_N, WE_N, IVECF_N}, so the mux is a single struct select.
- One sub-module, s32x_sh2_bus_mux: combinational struct select plus WAIT_N routing.
- The FSM and watchdog stay in the top module.

Test Plan:
- Idle after reset: MST_A = 27'h0000100, SLV_A = 27'h0000200 → A = 27'h0000100, OWNER = 0, MST_BRLS_N = 1, SLV_BACK_N = 1.
- Full handover: SLV_BREQ_N = 0 → MST_BRLS_N = 0 on the next CE_F. Then MST_BGR_N = 0 → SLV_BACK_N = 0 and OWNER = 1 on the next CE_F, A = 27'h0000200. SLV_WAIT_N follows WAIT_N; MST_WAIT_N = 1.
- Release: in SLV, SLV_BREQ_N = 1 → SLV_BACK_N = 1 and MST_BRLS_N = 1 on one CE_F. MST_BGR_N = 1 → OWNER = 0 on the next CE_F.
- Withdrawn request: SLV_BREQ_N pulses low for exactly 1 CE_F tick and returns high before the grant, while MST_BGR_N = 0 arrives on that same tick → state RET, SLV_BACK_N stays 1, OWNER stays 0.
- Async reset in SLV: RST asserted between CE ticks → OWNER = 0 and SLV_BACK_N = 1 within the same cycle, A = MST_A.
- Watchdog (macro on, WDT_LIMIT = 8'd4): SLV_BREQ_N = 0, MST_BGR_N held 1 → ERR = 1 after 4 CE_F ticks in FWD. ERR stays 1 after a later grant, and clears only on RST.

Source files
------------

// File: rtl/s32x_sh2_bus_arb_pkg.sv
// Shared SH7604/32X types: arbiter state encoding and the SH-2 bus output group.
// The bus group is one packed struct so ownership muxing is a single select.
package s32x_sh2_bus_arb_pkg;

  typedef enum logic [1:0] {
    MST = 2'b00,
    FWD = 2'b01,
    SLV = 2'b10,
    RET = 2'b11
  } ArbState_t;

  typedef struct packed {
    logic [26:0] A;
    logic [31:0] DO;
    logic        BS_N;
    logic [3:0]  CS_N;
    logic        RD_WR_N;
    logic        RD_N;
    logic [3:0]  WE_N;
    logic        IVECF_N;
  } SH2BusOut_t;

endpackage

// File: rtl/s32x_sh2_bus_arb_if.sv
// Bus bundle between the two SH-2 BSCs, the arbiter and the 32X address decoder.
// "slave" is the arbiter's view, "master" is the surrounding system's view.
interface s32x_sh2_bus_arb_if;

  logic [26:0] MST_A, SLV_A, A;
  logic [31:0] MST_DO, SLV_DO, DO;
  logic        MST_BS_N, SLV_BS_N, BS_N;
  logic [3:0]  MST_CS_N, SLV_CS_N, CS_N;
  logic        MST_RD_WR_N, SLV_RD_WR_N, RD_WR_N;
  logic        MST_RD_N, SLV_RD_N, RD_N;
  logic [3:0]  MST_WE_N, SLV_WE_N, WE_N;
  logic        MST_IVECF_N, SLV_IVECF_N, IVECF_N;
  logic        MST_BGR_N, SLV_BREQ_N;
  logic        MST_BRLS_N, SLV_BACK_N;
  logic        MST_WAIT_N, SLV_WAIT_N, WAIT_N;
  logic        OWNER, ERR;

  modport slave (
    input  MST_A, SLV_A, MST_DO, SLV_DO, MST_BS_N, SLV_BS_N, MST_CS_N, SLV_CS_N,
           MST_RD_WR_N, SLV_RD_WR_N, MST_RD_N, SLV_RD_N, MST_WE_N, SLV_WE_N,
           MST_IVECF_N, SLV_IVECF_N, MST_BGR_N, SLV_BREQ_N, WAIT_N,
    output MST_BRLS_N, SLV_BACK_N, MST_WAIT_N, SLV_WAIT_N,
           A, DO, BS_N, CS_N, RD_WR_N, RD_N, WE_N, IVECF_N, OWNER, ERR
  );

  modport master (
    output MST_A, SLV_A, MST_DO, SLV_DO, MST_BS_N, SLV_BS_N, MST_CS_N, SLV_CS_N,
           MST_RD_WR_N, SLV_RD_WR_N, MST_RD_N, SLV_RD_N, MST_WE_N, SLV_WE_N,
           MST_IVECF_N, SLV_IVECF_N, MST_BGR_N, SLV_BREQ_N, WAIT_N,
    input  MST_BRLS_N, SLV_BACK_N, MST_WAIT_N, SLV_WAIT_N,
           A, DO, BS_N, CS_N, RD_WR_N, RD_N, WE_N, IVECF_N, OWNER, ERR
  );

endinterface

// File: rtl/s32x_sh2_bus_arb_mux.sv
// Owner-selected SH-2 bus output mux and WAIT_N return routing.
// Purely combinational, zero latency; the non-owner always sees WAIT_N released.
module s32x_sh2_bus_mux
  import s32x_sh2_bus_arb_pkg::*;
(
  input  SH2BusOut_t mst_bus,
  input  SH2BusOut_t slv_bus,
  input  logic       owner,
  input  logic       wait_n,
  output SH2BusOut_t shr_bus,
  output logic       mst_wait_n,
  output logic       slv_wait_n
);

  assign shr_bus    = owner ? slv_bus : mst_bus;
  assign mst_wait_n = owner ? 1'b1 : wait_n;
  assign slv_wait_n = owner ? wait_n : 1'b1;

endmodule

// File: rtl/s32x_sh2_bus_arb.sv
// Master/slave SH-2 bus arbiter: forwards BREQ->BRLS, BGR->BACK, muxes the owner onto the bus.
// Optional grant watchdog (sticky ERR) built only when S32X_BUS_ARB_WDT_EN is defined.
module s32x_sh2_bus_arb
  import s32x_sh2_bus_arb_pkg::*;
#(
  parameter logic [7:0] WDT_LIMIT = 8'd255
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE_R,
  input  logic CE_F,
  s32x_sh2_bus_arb_if.slave bus
);

  localparam logic [1:0] ST_MST = MST;
  localparam logic [1:0] ST_FWD = FWD;
  localparam logic [1:0] ST_SLV = SLV;
  localparam logic [1:0] ST_RET = RET;

  logic [1:0] state_d, state_q;
  logic       brls_n_d, brls_n_q;
  logic       back_n_d, back_n_q;
  logic       owner_d, owner_q;

  // Rising-phase enable is not needed: the BSC handshake is sampled on CE_F only.
  logic unused_ce;
  assign unused_ce = ^{CE_R, WDT_LIMIT};

  always_comb begin
    state_d  = state_q;
    brls_n_d = brls_n_q;
    back_n_d = back_n_q;
    owner_d  = owner_q;
    case (state_q)
      ST_MST: begin
        if (!bus.SLV_BREQ_N) begin
          brls_n_d = 1'b0;
          state_d  = ST_FWD;
        end
      end
      ST_FWD: begin
        if (bus.SLV_BREQ_N) begin
          brls_n_d = 1'b1;
          state_d  = ST_RET;
        end else if (!bus.MST_BGR_N) begin
          back_n_d = 1'b0;
          owner_d  = 1'b1;
          state_d  = ST_SLV;
        end
      end
      ST_SLV: begin
        if (bus.SLV_BREQ_N) begin
          back_n_d = 1'b1;
          brls_n_d = 1'b1;
          state_d  = ST_RET;
        end
      end
      default: begin
        // Hold ownership until the master drops its grant, so it always gets a window.
        if (bus.MST_BGR_N) begin
          owner_d = 1'b0;
          state_d = ST_MST;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_MST;
      brls_n_q <= 1'b1;
      back_n_q <= 1'b1;
      owner_q  <= 1'b0;
    end else if (CE_F) begin
      state_q  <= state_d;
      brls_n_q <= brls_n_d;
      back_n_q <= back_n_d;
      owner_q  <= owner_d;
    end
  end

`ifdef S32X_BUS_ARB_WDT_EN
  logic [7:0] wdt_cnt_d, wdt_cnt_q;
  logic       err_d, err_q;

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    err_d     = err_q;
    if (state_q == ST_FWD) begin
      if (wdt_cnt_q != 8'hFF) wdt_cnt_d = wdt_cnt_q + 8'd1;
      if (wdt_cnt_d == WDT_LIMIT) err_d = 1'b1;
    end else if (state_d == ST_FWD) begin
      wdt_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdt_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else if (CE_F) begin
      wdt_cnt_q <= wdt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif

  SH2BusOut_t mst_bus, slv_bus, shr_bus;

  assign mst_bus = '{A: bus.MST_A, DO: bus.MST_DO, BS_N: bus.MST_BS_N, CS_N: bus.MST_CS_N,
                     RD_WR_N: bus.MST_RD_WR_N, RD_N: bus.MST_RD_N, WE_N: bus.MST_WE_N,
                     IVECF_N: bus.MST_IVECF_N};
  assign slv_bus = '{A: bus.SLV_A, DO: bus.SLV_DO, BS_N: bus.SLV_BS_N, CS_N: bus.SLV_CS_N,
                     RD_WR_N: bus.SLV_RD_WR_N, RD_N: bus.SLV_RD_N, WE_N: bus.SLV_WE_N,
                     IVECF_N: bus.SLV_IVECF_N};

  s32x_sh2_bus_mux u_mux (
    .mst_bus    (mst_bus),
    .slv_bus    (slv_bus),
    .owner      (owner_q),
    .wait_n     (bus.WAIT_N),
    .shr_bus    (shr_bus),
    .mst_wait_n (bus.MST_WAIT_N),
    .slv_wait_n (bus.SLV_WAIT_N)
  );

  assign bus.A          = shr_bus.A;
  assign bus.DO         = shr_bus.DO;
  assign bus.BS_N       = shr_bus.BS_N;
  assign bus.CS_N       = shr_bus.CS_N;
  assign bus.RD_WR_N    = shr_bus.RD_WR_N;
  assign bus.RD_N       = shr_bus.RD_N;
  assign bus.WE_N       = shr_bus.WE_N;
  assign bus.IVECF_N    = shr_bus.IVECF_N;
  assign bus.MST_BRLS_N = brls_n_q;
  assign bus.SLV_BACK_N = back_n_q;
  assign bus.OWNER      = owner_q;

endmodule

// File: tb/tb_s32x_sh2_bus_arb.sv
// Bench for s32x_sh2_bus_arb: directed handshake scenarios plus randomized traffic
// checked against a phase-level model of who holds the bus.
module tb_s32x_sh2_bus_arb;
  import s32x_sh2_bus_arb_pkg::*;

`ifdef S32X_BUS_ARB_WDT_EN
  localparam logic [7:0] LIM    = 8'd4;
  localparam bit         WDT_ON = 1'b1;
`else
  localparam logic [7:0] LIM    = 8'd255;
  localparam bit         WDT_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, CE_R, CE_F;
  always #5 CLK = ~CLK;

  s32x_sh2_bus_arb_if bus_if ();

  s32x_sh2_bus_arb #(.WDT_LIMIT(LIM)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .CE_R (CE_R),
    .CE_F (CE_F),
    .bus  (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model phases: 0 master idle, 1 request pending, 2 slave granted, 3 returning.
  int m_st;
  bit m_owner;
  int m_fwd;
  bit m_err;

  function automatic void model_reset();
    m_st = 0; m_owner = 1'b0; m_fwd = 0; m_err = 1'b0;
  endfunction

  function automatic void model_tick(input bit breq_n, input bit bgr_n);
    case (m_st)
      0: if (!breq_n) begin m_st = 1; m_fwd = 0; end
      1: begin
        m_fwd = m_fwd + 1;
        if (WDT_ON && m_fwd >= int'(LIM)) m_err = 1'b1;
        if (breq_n) m_st = 3;
        else if (!bgr_n) begin m_st = 2; m_owner = 1'b1; end
      end
      2: if (breq_n) m_st = 3;
      default: if (bgr_n) begin m_st = 0; m_owner = 1'b0; end
    endcase
  endfunction

  function automatic bit exp_brls_n(); return !(m_st == 1 || m_st == 2); endfunction
  function automatic bit exp_back_n(); return !(m_st == 2); endfunction

  function automatic SH2BusOut_t mst_in();
    return '{bus_if.MST_A, bus_if.MST_DO, bus_if.MST_BS_N, bus_if.MST_CS_N,
             bus_if.MST_RD_WR_N, bus_if.MST_RD_N, bus_if.MST_WE_N, bus_if.MST_IVECF_N};
  endfunction

  function automatic SH2BusOut_t slv_in();
    return '{bus_if.SLV_A, bus_if.SLV_DO, bus_if.SLV_BS_N, bus_if.SLV_CS_N,
             bus_if.SLV_RD_WR_N, bus_if.SLV_RD_N, bus_if.SLV_WE_N, bus_if.SLV_IVECF_N};
  endfunction

  function automatic SH2BusOut_t shr_out();
    return '{bus_if.A, bus_if.DO, bus_if.BS_N, bus_if.CS_N,
             bus_if.RD_WR_N, bus_if.RD_N, bus_if.WE_N, bus_if.IVECF_N};
  endfunction

  task automatic rand_bus();
    bus_if.MST_DO = $urandom;          bus_if.SLV_DO = $urandom;
    bus_if.MST_BS_N = 1'($urandom);    bus_if.SLV_BS_N = 1'($urandom);
    bus_if.MST_CS_N = 4'($urandom);    bus_if.SLV_CS_N = 4'($urandom);
    bus_if.MST_RD_WR_N = 1'($urandom); bus_if.SLV_RD_WR_N = 1'($urandom);
    bus_if.MST_RD_N = 1'($urandom);    bus_if.SLV_RD_N = 1'($urandom);
    bus_if.MST_WE_N = 4'($urandom);    bus_if.SLV_WE_N = 4'($urandom);
    bus_if.MST_IVECF_N = 1'($urandom); bus_if.SLV_IVECF_N = 1'($urandom);
    bus_if.WAIT_N = 1'($urandom);
  endtask

  // One clock; the model advances only when CE_F is sampled high outside reset.
  task automatic tick(input bit cef);
    CE_F = cef;
    CE_R = !cef;
    @(posedge CLK);
    if (cef && !RST) model_tick(bus_if.SLV_BREQ_N, bus_if.MST_BGR_N);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE_F = 1'b0; CE_R = 1'b0;
    rand_bus();
    bus_if.MST_A = 27'h0000100; bus_if.SLV_A = 27'h0000200;
    bus_if.SLV_BREQ_N = 1'b1; bus_if.MST_BGR_N = 1'b1; bus_if.WAIT_N = 1'b1;
    model_reset();
    #3;
    n_checks++;
    if ({bus_if.OWNER, bus_if.MST_BRLS_N, bus_if.SLV_BACK_N, bus_if.ERR} !== 4'b0110) begin
      n_fail++;
      $display("FAIL reset_flags got owner/brls/back/err=%b%b%b%b want 0110", bus_if.OWNER,
               bus_if.MST_BRLS_N, bus_if.SLV_BACK_N, bus_if.ERR);
    end
    n_checks++;
    if (bus_if.A !== 27'h0000100) begin
      n_fail++; $display("FAIL reset_addr got A=%h want 0000100", bus_if.A);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    tick(1'b1);
    n_checks++;
    if (shr_out() !== mst_in() || bus_if.OWNER !== 1'b0) begin
      n_fail++; $display("FAIL idle_mirror got bus=%h owner=%b want bus=%h owner=0",
                         shr_out(), bus_if.OWNER, mst_in());
    end
  endtask

  task automatic test_handover();
    bus_if.SLV_BREQ_N = 1'b0;
    tick(1'b0);
    n_checks++;
    if (bus_if.MST_BRLS_N !== 1'b1) begin
      n_fail++; $display("FAIL no_ce_hold got brls=%b want 1", bus_if.MST_BRLS_N);
    end
    tick(1'b1);
    n_checks++;
    if ({bus_if.MST_BRLS_N, bus_if.SLV_BACK_N, bus_if.OWNER} !== 3'b010) begin
      n_fail++; $display("FAIL req_fwd got brls/back/owner=%b%b%b want 010",
                         bus_if.MST_BRLS_N, bus_if.SLV_BACK_N, bus_if.OWNER);
    end
    bus_if.MST_BGR_N = 1'b0;
    tick(1'b1);
    n_checks++;
    if ({bus_if.SLV_BACK_N, bus_if.OWNER} !== 2'b01 || bus_if.A !== 27'h0000200) begin
      n_fail++; $display("FAIL grant got back=%b owner=%b A=%h want 0 1 0000200",
                         bus_if.SLV_BACK_N, bus_if.OWNER, bus_if.A);
    end
    for (int i = 0; i < 4; i++) begin
      bus_if.WAIT_N = i[0];
      #1;
      n_checks++;
      if (bus_if.SLV_WAIT_N !== bus_if.WAIT_N || bus_if.MST_WAIT_N !== 1'b1) begin
        n_fail++; $display("FAIL slv_wait got slv=%b mst=%b want slv=%b mst=1",
                           bus_if.SLV_WAIT_N, bus_if.MST_WAIT_N, i[0]);
      end
    end
  endtask

  task automatic test_release();
    bus_if.SLV_BREQ_N = 1'b1;
    tick(1'b1);
    n_checks++;
    if ({bus_if.SLV_BACK_N, bus_if.MST_BRLS_N, bus_if.OWNER} !== 3'b111) begin
      n_fail++; $display("FAIL release got back/brls/owner=%b%b%b want 111",
                         bus_if.SLV_BACK_N, bus_if.MST_BRLS_N, bus_if.OWNER);
    end
    tick(1'b1);
    n_checks++;
    if (bus_if.OWNER !== 1'b1) begin
      n_fail++; $display("FAIL ret_hold got owner=%b want 1", bus_if.OWNER);
    end
    bus_if.MST_BGR_N = 1'b1;
    tick(1'b1);
    bus_if.WAIT_N = 1'b0;
    #1;
    n_checks++;
    if (bus_if.OWNER !== 1'b0 || bus_if.A !== 27'h0000100 || bus_if.MST_WAIT_N !== 1'b0
        || bus_if.SLV_WAIT_N !== 1'b1) begin
      n_fail++; $display("FAIL return got owner=%b A=%h mw=%b sw=%b want 0 0000100 0 1",
                         bus_if.OWNER, bus_if.A, bus_if.MST_WAIT_N, bus_if.SLV_WAIT_N);
    end
    bus_if.WAIT_N = 1'b1;
  endtask

  task automatic test_withdrawn();
    bus_if.SLV_BREQ_N = 1'b0;
    tick(1'b1);
    bus_if.SLV_BREQ_N = 1'b1; bus_if.MST_BGR_N = 1'b0;
    tick(1'b1);
    n_checks++;
    if ({bus_if.SLV_BACK_N, bus_if.OWNER, bus_if.MST_BRLS_N} !== 3'b101) begin
      n_fail++; $display("FAIL withdraw got back/owner/brls=%b%b%b want 101",
                         bus_if.SLV_BACK_N, bus_if.OWNER, bus_if.MST_BRLS_N);
    end
    bus_if.SLV_BREQ_N = 1'b0;
    tick(1'b1);
    n_checks++;
    if (bus_if.MST_BRLS_N !== 1'b1) begin
      n_fail++; $display("FAIL ret_no_service got brls=%b want 1", bus_if.MST_BRLS_N);
    end
    bus_if.MST_BGR_N = 1'b1;
    tick(1'b1);
    n_checks++;
    if (bus_if.MST_BRLS_N !== 1'b1 || bus_if.OWNER !== 1'b0) begin
      n_fail++; $display("FAIL master_window got brls=%b owner=%b want 1 0",
                         bus_if.MST_BRLS_N, bus_if.OWNER);
    end
    tick(1'b1);
    n_checks++;
    if (bus_if.MST_BRLS_N !== 1'b0) begin
      n_fail++; $display("FAIL re_request got brls=%b want 0", bus_if.MST_BRLS_N);
    end
    bus_if.SLV_BREQ_N = 1'b1;
    tick(1'b1);
    tick(1'b1);
  endtask

  task automatic test_async_reset();
    bus_if.SLV_BREQ_N = 1'b0;
    tick(1'b1);
    bus_if.MST_BGR_N = 1'b0;
    tick(1'b1);
    n_checks++;
    if (bus_if.OWNER !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_slv got owner=%b want 1", bus_if.OWNER);
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.OWNER, bus_if.SLV_BACK_N, bus_if.MST_BRLS_N} !== 3'b011
        || shr_out() !== mst_in()) begin
      n_fail++; $display("FAIL async_reset got owner/back/brls=%b%b%b bus=%h want 011 bus=%h",
                         bus_if.OWNER, bus_if.SLV_BACK_N, bus_if.MST_BRLS_N, shr_out(), mst_in());
    end
    model_reset();
    bus_if.SLV_BREQ_N = 1'b1; bus_if.MST_BGR_N = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    tick(1'b1);
  endtask

  task automatic test_watchdog();
    bus_if.SLV_BREQ_N = 1'b0; bus_if.MST_BGR_N = 1'b1;
    tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      tick(1'b1);
      n_checks++;
      if (bus_if.ERR !== (WDT_ON && i == 3)) begin
        n_fail++; $display("FAIL wdt_tick%0d got err=%b want %b", i, bus_if.ERR, WDT_ON && i == 3);
      end
    end
    bus_if.MST_BGR_N = 1'b0;
    tick(1'b1);
    bus_if.SLV_BREQ_N = 1'b1;
    tick(1'b1);
    bus_if.MST_BGR_N = 1'b1;
    tick(1'b1);
    n_checks++;
    if (bus_if.ERR !== WDT_ON || bus_if.OWNER !== 1'b0) begin
      n_fail++; $display("FAIL wdt_sticky got err=%b owner=%b want %b 0",
                         bus_if.ERR, bus_if.OWNER, WDT_ON);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (bus_if.ERR !== 1'b0) begin
      n_fail++; $display("FAIL wdt_clear got err=%b want 0", bus_if.ERR);
    end
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_random();
    bit breq_n = 1'b1, bgr_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rand_bus();
      bus_if.MST_A = 27'($urandom); bus_if.SLV_A = 27'($urandom);
      if ($urandom_range(0, 5) == 0) breq_n = !breq_n;
      if ($urandom_range(0, 3) == 0) bgr_n = !bgr_n;
      bus_if.SLV_BREQ_N = breq_n; bus_if.MST_BGR_N = bgr_n;
      tick($urandom_range(0, 2) != 0);
      n_checks++;
      if (bus_if.OWNER !== m_owner || bus_if.MST_BRLS_N !== exp_brls_n()
          || bus_if.SLV_BACK_N !== exp_back_n() || bus_if.ERR !== m_err
          || shr_out() !== (m_owner ? slv_in() : mst_in())
          || bus_if.MST_WAIT_N !== (m_owner ? 1'b1 : bus_if.WAIT_N)
          || bus_if.SLV_WAIT_N !== (m_owner ? bus_if.WAIT_N : 1'b1)) begin
        n_fail++;
        $display("FAIL rand_c%0d got o/brls/back/err=%b%b%b%b mw/sw=%b%b bus=%h want %b%b%b%b bus=%h",
                 c, bus_if.OWNER, bus_if.MST_BRLS_N, bus_if.SLV_BACK_N, bus_if.ERR,
                 bus_if.MST_WAIT_N, bus_if.SLV_WAIT_N, shr_out(), m_owner, exp_brls_n(),
                 exp_back_n(), m_err, m_owner ? slv_in() : mst_in());
      end
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_release();
    test_withdrawn();
    test_async_reset();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
